// File: rtl/result_pipe.sv
// Result pipeline from ALU output to register-file write port, with youngest-match forwarding.
// Optional late (load) data merge is enabled by defining RESULT_PIPE_LATE_EN.
module result_pipe #(
  parameter int XLEN       = 32,
  parameter int REGW       = 5,
  parameter int STAGES     = 3,
  parameter int NREAD      = 2,
  parameter int LATE_STAGE = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic [STAGES-1:0]     flush,
  input  logic                  in_valid,
  input  logic                  in_wen,
  input  logic [REGW-1:0]       in_rd,
  input  logic [XLEN-1:0]       in_data,
`ifdef RESULT_PIPE_LATE_EN
  input  logic                  in_late,
  input  logic [XLEN-1:0]       ld_data,
  input  logic                  ld_valid,
  output logic [NREAD-1:0]      fwd_pending,
`endif
  input  logic [NREAD*REGW-1:0] rs,
  output logic [NREAD-1:0]      fwd_hit,
  output logic [NREAD*XLEN-1:0] fwd_data,
  output logic                  ret_valid,
  output logic [REGW-1:0]       ret_rd,
  output logic [XLEN-1:0]       ret_data
);

  if (STAGES < 2 || LATE_STAGE < 0 || LATE_STAGE >= STAGES) begin : g_bad_param
    $error("result_pipe: STAGES must be >= 2 and LATE_STAGE within 0..STAGES-1");
  end

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] wen;
  logic [REGW-1:0]   rd       [STAGES];
  logic [XLEN-1:0]   data     [STAGES];
  logic [REGW-1:0]   nxt_rd   [STAGES];
  logic [XLEN-1:0]   nxt_data [STAGES];
`ifdef RESULT_PIPE_LATE_EN
  logic [STAGES-1:0] late;
  logic [STAGES-1:0] nxt_late;
`endif

  always_comb begin
    nxt_rd[0]   = in_rd;
    nxt_data[0] = in_data;
    for (int i = 1; i < STAGES; i++) begin
      nxt_rd[i]   = rd[i-1];
      nxt_data[i] = data[i-1];
    end
`ifdef RESULT_PIPE_LATE_EN
    nxt_late = {late[STAGES-2:0], in_late};
    // the entry moving into LATE_STAGE picks up the load result if it is waiting on one
    if (nxt_late[LATE_STAGE] && ld_valid) begin
      nxt_data[LATE_STAGE] = ld_data;
      nxt_late[LATE_STAGE] = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld <= '0;
      wen <= '0;
      for (int i = 0; i < STAGES; i++) begin
        rd[i]   <= '0;
        data[i] <= '0;
      end
`ifdef RESULT_PIPE_LATE_EN
      late <= '0;
`endif
    end else begin
      // flush clears valid whether the pipe shifts or holds
      if (stall) begin
        vld <= vld & ~flush;
      end else begin
        vld  <= {vld[STAGES-2:0], in_valid} & ~flush;
        wen  <= {wen[STAGES-2:0], in_wen};
        rd   <= nxt_rd;
        data <= nxt_data;
`ifdef RESULT_PIPE_LATE_EN
        late <= nxt_late;
`endif
      end
    end
  end

  assign ret_valid = vld[STAGES-1] & wen[STAGES-1] & (rd[STAGES-1] != '0) & ~stall;
  assign ret_rd    = rd[STAGES-1];
`ifdef RESULT_PIPE_LATE_EN
  assign ret_data  = late[STAGES-1] ? ld_data : data[STAGES-1];
`else
  assign ret_data  = data[STAGES-1];
`endif

  // scan oldest to youngest so the youngest matching producer is written last
  always_comb begin
    fwd_hit  = '0;
    fwd_data = '0;
`ifdef RESULT_PIPE_LATE_EN
    fwd_pending = '0;
`endif
    for (int k = 0; k < NREAD; k++) begin
      for (int i = STAGES - 1; i >= 0; i--) begin
        if (vld[i] && wen[i] && (rd[i] == rs[k*REGW +: REGW]) && (rs[k*REGW +: REGW] != '0)) begin
`ifdef RESULT_PIPE_LATE_EN
          fwd_pending[k]           = late[i];
          fwd_hit[k]               = ~late[i];
          fwd_data[k*XLEN +: XLEN] = late[i] ? '0 : data[i];
`else
          fwd_hit[k]               = 1'b1;
          fwd_data[k*XLEN +: XLEN] = data[i];
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_result_pipe.sv
// Directed table-driven bench for result_pipe at default parameters (3 stages, 2 read ports).
// Late-data sequence is included when RESULT_PIPE_LATE_EN is defined.
module tb_result_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [2:0]  flush;
  logic        in_valid, in_wen;
  logic [4:0]  in_rd;
  logic [31:0] in_data;
  logic [9:0]  rs;
  logic [1:0]  fwd_hit;
  logic [63:0] fwd_data;
  logic        ret_valid;
  logic [4:0]  ret_rd;
  logic [31:0] ret_data;
`ifdef RESULT_PIPE_LATE_EN
  logic        in_late, ld_valid;
  logic [31:0] ld_data;
  logic [1:0]  fwd_pending;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  result_pipe dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_wen(in_wen), .in_rd(in_rd), .in_data(in_data),
`ifdef RESULT_PIPE_LATE_EN
    .in_late(in_late), .ld_data(ld_data), .ld_valid(ld_valid), .fwd_pending(fwd_pending),
`endif
    .rs(rs), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .ret_valid(ret_valid), .ret_rd(ret_rd), .ret_data(ret_data)
  );

  typedef struct {
    logic        st;
    logic [2:0]  fl;
    logic        iv, iw;
    logic [4:0]  ird;
    logic [31:0] idat;
    logic [4:0]  rs0, rs1;
    logic        rv;
    logic [4:0]  rrd;
    logic [31:0] rdat;
    logic [1:0]  hit;
    logic [31:0] f0, f1;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic st, logic [2:0] fl, logic iv, logic iw, logic [4:0] ird,
                              logic [31:0] idat, logic [4:0] rs0, logic [4:0] rs1, logic rv,
                              logic [4:0] rrd, logic [31:0] rdat, logic [1:0] hit,
                              logic [31:0] f0, logic [31:0] f1);
    vec_t v;
    v.st = st; v.fl = fl; v.iv = iv; v.iw = iw; v.ird = ird; v.idat = idat;
    v.rs0 = rs0; v.rs1 = rs1; v.rv = rv; v.rrd = rrd; v.rdat = rdat;
    v.hit = hit; v.f0 = f0; v.f1 = f1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic [2:0] fl, input logic iv, input logic iw,
                       input logic [4:0] ird, input logic [31:0] idat,
                       input logic [4:0] rs0, input logic [4:0] rs1);
    stall = st; flush = fl; in_valid = iv; in_wen = iw; in_rd = ird; in_data = idat;
    rs = {rs1, rs0};
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " ret_valid"}, 32'(ret_valid), 32'd0);
    chk({tag, " fwd_hit"},   32'(fwd_hit),   32'd0);
    chk({tag, " fwd_data0"}, fwd_data[31:0],  32'd0);
    chk({tag, " fwd_data1"}, fwd_data[63:32], 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 3'b000, 1, 1, 5'd5, 32'h11, 5'd5, 5'd5);
`ifdef RESULT_PIPE_LATE_EN
    in_late = 1'b0; ld_valid = 1'b0; ld_data = '0;
`endif

    // stall flush iv iw rd data | rs0 rs1 | rv rrd rdat | hit f0 f1
    vt.push_back(mk(0,3'b000,1,1, 5,'h11,    5, 0, 0,0,0,        2'b00,0,0));
    vt.push_back(mk(0,3'b000,1,1, 6,'h22,    5, 6, 0,0,0,        2'b01,'h11,0));
    vt.push_back(mk(0,3'b000,1,1, 7,'h33,    5, 6, 0,0,0,        2'b11,'h11,'h22));
    vt.push_back(mk(0,3'b000,0,0, 0,0,       7, 5, 1,5,'h11,     2'b11,'h33,'h11));
    vt.push_back(mk(0,3'b000,0,0, 0,0,       6, 0, 1,6,'h22,     2'b01,'h22,0));
    vt.push_back(mk(0,3'b000,1,1, 3,'hAAAA,  3, 7, 1,7,'h33,     2'b10,0,'h33));
    vt.push_back(mk(0,3'b000,1,1, 0,'h5555,  3, 0, 0,0,0,        2'b01,'hAAAA,0));
    vt.push_back(mk(0,3'b000,1,1, 3,'hBBBB,  3, 0, 0,0,0,        2'b01,'hAAAA,0));
    vt.push_back(mk(0,3'b000,0,0, 0,0,       3, 0, 1,3,'hAAAA,   2'b01,'hBBBB,0));
    vt.push_back(mk(0,3'b000,0,0, 0,0,       3, 0, 0,0,0,        2'b01,'hBBBB,0));
    vt.push_back(mk(0,3'b000,1,0,12,'h77,    3, 0, 1,3,'hBBBB,   2'b01,'hBBBB,0));
    vt.push_back(mk(0,3'b000,0,0, 0,0,      12, 3, 0,0,0,        2'b00,0,0));
    vt.push_back(mk(0,3'b000,0,0, 0,0,      12, 0, 0,0,0,        2'b00,0,0));
    vt.push_back(mk(0,3'b000,0,0, 0,0,      12, 0, 0,0,0,        2'b00,0,0));
    vt.push_back(mk(0,3'b000,1,1, 9,'h99,    9, 0, 0,0,0,        2'b00,0,0));
    vt.push_back(mk(0,3'b000,0,0, 0,0,       9, 0, 0,0,0,        2'b01,'h99,0));
    vt.push_back(mk(0,3'b000,1,1,11,'hBB,    9,11, 0,0,0,        2'b01,'h99,0));
    for (int s = 0; s < 4; s++)
      vt.push_back(mk(1,3'b000,1,1,10,'hA0,  9,11, 0,0,0,        2'b11,'h99,'hBB));
    vt.push_back(mk(0,3'b000,0,0, 0,0,       9,11, 1,9,'h99,     2'b11,'h99,'hBB));
    vt.push_back(mk(0,3'b000,0,0, 0,0,      10,11, 0,0,0,        2'b10,0,'hBB));
    vt.push_back(mk(0,3'b000,0,0, 0,0,       9,10, 1,11,'hBB,    2'b00,0,0));
    vt.push_back(mk(0,3'b000,1,1, 4,'h44,    4, 0, 0,0,0,        2'b00,0,0));
    vt.push_back(mk(1,3'b001,0,0, 0,0,       4, 0, 0,0,0,        2'b01,'h44,0));
    vt.push_back(mk(0,3'b000,0,0, 0,0,       4, 0, 0,0,0,        2'b00,0,0));
    vt.push_back(mk(0,3'b000,0,0, 0,0,       4, 0, 0,0,0,        2'b00,0,0));
    vt.push_back(mk(0,3'b000,0,0, 0,0,       4, 0, 0,0,0,        2'b00,0,0));
    vt.push_back(mk(0,3'b000,1,1,13,'h13,   13, 0, 0,0,0,        2'b00,0,0));
    vt.push_back(mk(0,3'b000,1,1,14,'h14,   13,14, 0,0,0,        2'b01,'h13,0));
    vt.push_back(mk(0,3'b100,0,0, 0,0,      13,14, 0,0,0,        2'b11,'h13,'h14));
    vt.push_back(mk(0,3'b000,0,0, 0,0,      13,14, 0,0,0,        2'b10,0,'h14));
    vt.push_back(mk(0,3'b000,0,0, 0,0,      13,14, 1,14,'h14,    2'b10,0,'h14));

    // reset held with a valid entry presented
    repeat (2) @(posedge clk);
    #2;
    chk_quiet("reset");
    chk("reset ret_rd",   32'(ret_rd), 32'd0);
    chk("reset ret_data", ret_data,    32'd0);
    reset = 1'b1;
    drive(0, 3'b000, 0, 0, 5'd0, 32'd0, 5'd5, 5'd0);

    foreach (vt[i]) begin
      @(posedge clk);
      #1;
      drive(vt[i].st, vt[i].fl, vt[i].iv, vt[i].iw, vt[i].ird, vt[i].idat, vt[i].rs0, vt[i].rs1);
      #1;
      chk($sformatf("v%0d ret_valid", i), 32'(ret_valid), 32'(vt[i].rv));
      if (vt[i].rv) begin
        chk($sformatf("v%0d ret_rd", i),   32'(ret_rd), 32'(vt[i].rrd));
        chk($sformatf("v%0d ret_data", i), ret_data,    vt[i].rdat);
      end
      chk($sformatf("v%0d fwd_hit", i),   32'(fwd_hit),   32'(vt[i].hit));
      chk($sformatf("v%0d fwd_data0", i), fwd_data[31:0],  vt[i].f0);
      chk($sformatf("v%0d fwd_data1", i), fwd_data[63:32], vt[i].f1);
    end

    // reset while an entry is about to retire: nothing retires, nothing forwards
    @(posedge clk); #1;
    drive(0, 3'b000, 1, 1, 5'd15, 32'h15, 5'd15, 5'd0);
    repeat (3) begin
      @(posedge clk); #1;
      drive(0, 3'b000, 0, 0, 5'd0, 32'd0, 5'd15, 5'd0);
    end
    #1;
    chk("pre-reset ret_valid", 32'(ret_valid), 32'd1);
    chk("pre-reset fwd_data0", fwd_data[31:0], 32'h15);
    reset = 1'b0;
    #1;
    chk_quiet("midreset");
    @(posedge clk); #1;
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #2;
      chk_quiet($sformatf("postreset%0d", c));
    end

`ifdef RESULT_PIPE_LATE_EN
    // load-use: rd8 waits on late data, merged as it moves into LATE_STAGE
    @(posedge clk); #1;
    drive(0, 3'b000, 1, 1, 5'd8, 32'd0, 5'd8, 5'd0);
    in_late = 1'b1;
    @(posedge clk); #1;
    drive(0, 3'b000, 0, 0, 5'd0, 32'd0, 5'd8, 5'd0);
    in_late = 1'b0; ld_data = 32'hDEAD; ld_valid = 1'b1;
    #1;
    chk("late pending", 32'(fwd_pending), 32'd1);
    chk("late hit0",    32'(fwd_hit),     32'd0);
    @(posedge clk); #1;
    ld_valid = 1'b0; ld_data = 32'h0;
    #1;
    chk("late pending after", 32'(fwd_pending), 32'd0);
    chk("late hit after",     32'(fwd_hit),     32'd1);
    chk("late fwd_data",      fwd_data[31:0],   32'hDEAD);
    @(posedge clk); #2;
    chk("late ret_valid", 32'(ret_valid), 32'd1);
    chk("late ret_rd",    32'(ret_rd),    32'd8);
    chk("late ret_data",  ret_data,       32'hDEAD);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
